// File: rtl/rob_commit_unit.sv
// Reorder buffer commit unit: tracks dispatched/finished entries and retires the head in program order.
// Optional macro ROB_PROTOCOL_CHECK_EN adds a sticky protocol-error flag.
module rob_commit_unit #(
    parameter int RRF_NUM  = 64,
    parameter int RRF_SEL  = 6,
    parameter int REG_SEL  = 5,
    parameter int ADDR_LEN = 32
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                dp_valid_i,
    input  logic [RRF_SEL-1:0]  dp_rrftag_i,
    input  logic                dp_dst_en_i,
    input  logic [REG_SEL-1:0]  dp_dstnum_i,
    input  logic [ADDR_LEN-1:0] dp_pc_i,
    input  logic                fin_alu1_we_i,
    input  logic [RRF_SEL-1:0]  fin_alu1_tag_i,
    input  logic                fin_alu2_we_i,
    input  logic [RRF_SEL-1:0]  fin_alu2_tag_i,
    input  logic                fin_ldst_we_i,
    input  logic [RRF_SEL-1:0]  fin_ldst_tag_i,
    input  logic                fin_mul_we_i,
    input  logic [RRF_SEL-1:0]  fin_mul_tag_i,
    input  logic                fin_branch_we_i,
    input  logic [RRF_SEL-1:0]  fin_branch_tag_i,
    output logic [1:0]          com_inst_num_o,
    output logic                completed_we_o,
    output logic [REG_SEL-1:0]  completed_dstnum_o,
    output logic [RRF_SEL-1:0]  completed_dst_rrftag_o,
    output logic [ADDR_LEN-1:0] commit_pc_o,
    output logic                rob_empty_o,
    output logic                proto_err_o
);
    localparam int FIN_UNITS = 5;

    logic [FIN_UNITS-1:0]              fin_we;
    logic [FIN_UNITS-1:0][RRF_SEL-1:0] fin_tag;

    logic [RRF_NUM-1:0]                valid, finished, dst_en;
    logic [RRF_NUM-1:0][REG_SEL-1:0]   dstnum;
    logic [RRF_NUM-1:0][ADDR_LEN-1:0]  pc;
    logic [RRF_SEL-1:0]                comptr;
    logic [RRF_SEL:0]                  count;

    logic [RRF_NUM-1:0]                dp_hit, fin_hit, retire_hit;
    logic                              cm, full;

    assign fin_we  = {fin_branch_we_i, fin_mul_we_i, fin_ldst_we_i, fin_alu2_we_i, fin_alu1_we_i};
    assign fin_tag = {fin_branch_tag_i, fin_mul_tag_i, fin_ldst_tag_i, fin_alu2_tag_i, fin_alu1_tag_i};

    assign cm   = valid[comptr] & finished[comptr];
    assign full = (count == (RRF_SEL+1)'(RRF_NUM));

    // One-hot per-entry event vectors; several finish units may hit the same entry.
    always_comb begin
        dp_hit     = '0;
        fin_hit    = '0;
        retire_hit = '0;
        for (int i = 0; i < RRF_NUM; i++) begin
            dp_hit[i]     = dp_valid_i && (dp_rrftag_i == RRF_SEL'(i));
            retire_hit[i] = cm && (comptr == RRF_SEL'(i));
            for (int u = 0; u < FIN_UNITS; u++) begin
                if (fin_we[u] && (fin_tag[u] == RRF_SEL'(i))) fin_hit[i] = 1'b1;
            end
        end
    end

    // Dispatch wins over both the commit clear and a same-cycle finish.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            valid    <= '0;
            finished <= '0;
            comptr   <= '0;
            count    <= '0;
        end else begin
            valid    <= (valid & ~retire_hit) | dp_hit;
            finished <= (finished | fin_hit) & ~dp_hit;
            if (cm) comptr <= comptr + 1'b1;
            if (dp_valid_i && !cm) begin
                if (!full) count <= count + 1'b1;
            end else if (!dp_valid_i && cm) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < RRF_NUM; i++) begin
            if (reset_i && dp_hit[i]) begin
                dst_en[i] <= dp_dst_en_i;
                dstnum[i] <= dp_dstnum_i;
                pc[i]     <= dp_pc_i;
            end
        end
    end

    assign com_inst_num_o         = {1'b0, cm};
    assign completed_we_o         = cm & dst_en[comptr];
    assign completed_dstnum_o     = cm ? dstnum[comptr] : '0;
    assign completed_dst_rrftag_o = comptr;
    assign commit_pc_o            = cm ? pc[comptr] : '0;
    assign rob_empty_o            = (count == '0);

`ifdef ROB_PROTOCOL_CHECK_EN
    logic proto_hit, proto_err_q;

    always_comb begin
        proto_hit = dp_valid_i && ((valid[dp_rrftag_i] && !retire_hit[dp_rrftag_i]) || full);
        for (int u = 0; u < FIN_UNITS; u++) begin
            if (fin_we[u] && !valid[fin_tag[u]] && !(dp_valid_i && (dp_rrftag_i == fin_tag[u])))
                proto_hit = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i)      proto_err_q <= 1'b0;
        else if (proto_hit) proto_err_q <= 1'b1;
    end

    assign proto_err_o = proto_err_q;
`else
    assign proto_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_rob_commit_unit.sv
// Bench for rob_commit_unit: directed steps plus random legal traffic against a queue-based ROB model.
module tb_rob_commit_unit;
    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        dp_valid;
    logic [5:0]  dp_tag;
    logic        dp_dst_en;
    logic [4:0]  dp_dstnum;
    logic [31:0] dp_pc;
    logic        fin_we  [5];
    logic [5:0]  fin_tag [5];

    logic [1:0]  com_inst_num;
    logic        completed_we;
    logic [4:0]  completed_dstnum;
    logic [5:0]  completed_rrftag;
    logic [31:0] commit_pc;
    logic        rob_empty;
    logic        proto_err;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    rob_commit_unit dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .dp_valid_i(dp_valid), .dp_rrftag_i(dp_tag), .dp_dst_en_i(dp_dst_en),
        .dp_dstnum_i(dp_dstnum), .dp_pc_i(dp_pc),
        .fin_alu1_we_i(fin_we[0]),   .fin_alu1_tag_i(fin_tag[0]),
        .fin_alu2_we_i(fin_we[1]),   .fin_alu2_tag_i(fin_tag[1]),
        .fin_ldst_we_i(fin_we[2]),   .fin_ldst_tag_i(fin_tag[2]),
        .fin_mul_we_i(fin_we[3]),    .fin_mul_tag_i(fin_tag[3]),
        .fin_branch_we_i(fin_we[4]), .fin_branch_tag_i(fin_tag[4]),
        .com_inst_num_o(com_inst_num), .completed_we_o(completed_we),
        .completed_dstnum_o(completed_dstnum), .completed_dst_rrftag_o(completed_rrftag),
        .commit_pc_o(commit_pc), .rob_empty_o(rob_empty), .proto_err_o(proto_err)
    );

    // Reference model: in-flight instructions in program order.
    typedef struct {
        int          tag;
        bit          dst_en;
        bit [4:0]    dstnum;
        bit [31:0]   pc;
        bit          fin;
    } ent_t;
    ent_t q[$];
    int   head = 0;
    bit   merr = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_cm();
        return q.size() > 0 && q[0].fin;
    endfunction

    task automatic check_all();
        bit cm;
        bit perr;
        cm = model_cm();
`ifdef ROB_PROTOCOL_CHECK_EN
        perr = merr;
`else
        perr = 1'b0;
`endif
        chk("com_inst_num", 64'(com_inst_num), 64'(cm));
        chk("completed_we", 64'(completed_we), 64'(cm && q[0].dst_en));
        chk("completed_dstnum", 64'(completed_dstnum), cm ? 64'(q[0].dstnum) : 64'd0);
        chk("completed_rrftag", 64'(completed_rrftag), 64'(head));
        chk("commit_pc", 64'(commit_pc), cm ? 64'(q[0].pc) : 64'd0);
        chk("rob_empty", 64'(rob_empty), 64'(q.size() == 0));
        chk("proto_err", 64'(proto_err), 64'(perr));
    endtask

    task automatic model_step();
        bit cm;
        ent_t e;
        if (!reset_i) begin
            q.delete();
            head = 0;
            merr = 0;
            return;
        end
        cm = model_cm();
        for (int u = 0; u < 5; u++) begin
            if (fin_we[u]) begin
                bit hit;
                hit = 0;
                foreach (q[k]) if (q[k].tag == int'(fin_tag[u])) begin q[k].fin = 1; hit = 1; end
                if (!hit && !(dp_valid && dp_tag == fin_tag[u])) merr = 1;
            end
        end
        if (dp_valid) begin
            bit busy;
            busy = 0;
            foreach (q[k]) if (q[k].tag == int'(dp_tag) && !(k == 0 && cm)) busy = 1;
            if (busy || q.size() >= 64) merr = 1;
        end
        if (cm) begin
            void'(q.pop_front());
            head = (head + 1) % 64;
        end
        if (dp_valid) begin
            e.tag = int'(dp_tag); e.dst_en = dp_dst_en; e.dstnum = dp_dstnum; e.pc = dp_pc; e.fin = 0;
            q.push_back(e);
        end
    endtask

    task automatic idle_inputs();
        dp_valid = 0; dp_tag = '0; dp_dst_en = 0; dp_dstnum = '0; dp_pc = '0;
        for (int u = 0; u < 5; u++) begin fin_we[u] = 0; fin_tag[u] = '0; end
    endtask

    // Check state at the falling edge, advance the model at the rising edge, then clear inputs.
    task automatic tick();
        @(negedge clk_i);
        check_all();
        @(posedge clk_i);
        model_step();
        #1;
        idle_inputs();
    endtask

    task automatic do_reset();
        reset_i = 0;
        tick();
        reset_i = 1;
    endtask

    task automatic dispatch(input int tag, input bit den, input int dn, input int pcv);
        dp_valid = 1; dp_tag = 6'(tag); dp_dst_en = den; dp_dstnum = 5'(dn); dp_pc = 32'(pcv);
    endtask

    task automatic finish(input int unit, input int tag);
        fin_we[unit] = 1; fin_tag[unit] = 6'(tag);
    endtask

    initial begin
        idle_inputs();
        reset_i = 0;
        tick();
        tick();
        reset_i = 1;

        // Reset / idle
        tick();
        chk("idle_empty", 64'(rob_empty), 64'd1);
        chk("idle_com", 64'(com_inst_num), 64'd0);
        chk("idle_we", 64'(completed_we), 64'd0);
        chk("idle_proto", 64'(proto_err), 64'd0);

        // Single instruction, minimum latency
        dispatch(0, 1, 5, 'h100); tick();
        chk("single_not_yet", 64'(com_inst_num), 64'd0);
        finish(0, 0); tick();
        chk("single_com", 64'(com_inst_num), 64'd1);
        chk("single_we", 64'(completed_we), 64'd1);
        chk("single_dstnum", 64'(completed_dstnum), 64'd5);
        chk("single_tag", 64'(completed_rrftag), 64'd0);
        chk("single_pc", 64'(commit_pc), 64'h100);
        tick();
        chk("single_empty_after", 64'(rob_empty), 64'd1);

        // Out-of-order finish, in-order retire
        do_reset();
        dispatch(0, 1, 1, 'h200); tick();
        dispatch(1, 1, 2, 'h204); tick();
        dispatch(2, 1, 3, 'h208); tick();
        finish(3, 2); tick();
        chk("ooo_hold2", 64'(com_inst_num), 64'd0);
        finish(4, 1); tick();
        chk("ooo_hold1", 64'(com_inst_num), 64'd0);
        finish(2, 0); tick();
        chk("ooo_ret0", 64'(completed_rrftag), 64'd0);
        chk("ooo_ret0_com", 64'(com_inst_num), 64'd1);
        tick();
        chk("ooo_ret1", 64'(completed_rrftag), 64'd1);
        chk("ooo_ret1_pc", 64'(commit_pc), 64'h204);
        tick();
        chk("ooo_ret2", 64'(completed_rrftag), 64'd2);
        chk("ooo_ret2_dst", 64'(completed_dstnum), 64'd3);
        tick();
        chk("ooo_empty", 64'(rob_empty), 64'd1);

        // No-destination instruction
        dispatch(3, 0, 7, 'h300); tick();
        finish(1, 3); tick();
        chk("nodst_com", 64'(com_inst_num), 64'd1);
        chk("nodst_we", 64'(completed_we), 64'd0);
        tick();

        // Advance the head to 62, then retire across the wrap
        while (head != 62) begin
            dispatch(head, 1, head % 32, head * 4);
            tick();
            finish(0, q[0].tag);
            tick();
            tick();
        end
        dispatch(62, 1, 10, 'h1000); tick();
        dispatch(63, 1, 11, 'h1004); tick();
        dispatch(0, 1, 12, 'h1008); tick();
        finish(0, 62); finish(1, 63); finish(3, 0); tick();
        chk("wrap_ret62", 64'(completed_rrftag), 64'd62);
        tick();
        chk("wrap_ret63", 64'(completed_rrftag), 64'd63);
        tick();
        chk("wrap_ret0", 64'(completed_rrftag), 64'd0);
        chk("wrap_ret0_pc", 64'(commit_pc), 64'h1008);
        tick();
        chk("wrap_ptr1", 64'(completed_rrftag), 64'd1);
        chk("wrap_empty", 64'(rob_empty), 64'd1);

`ifdef ROB_PROTOCOL_CHECK_EN
        finish(1, 9); tick();
        chk("proto_set", 64'(proto_err), 64'd1);
        tick(); tick();
        chk("proto_sticky", 64'(proto_err), 64'd1);
`endif

        // Reset mid-traffic, then a normal retire from tag 0
        dispatch(head, 1, 4, 'h500); tick();
        dispatch((head + 1) % 64, 1, 4, 'h504); finish(0, q[0].tag); tick();
        do_reset();
        chk("rst_empty", 64'(rob_empty), 64'd1);
        chk("rst_tag", 64'(completed_rrftag), 64'd0);
        chk("rst_proto", 64'(proto_err), 64'd0);
        dispatch(0, 1, 9, 'h600); tick();
        finish(4, 0); tick();
        chk("rst_retire_tag", 64'(completed_rrftag), 64'd0);
        chk("rst_retire_pc", 64'(commit_pc), 64'h600);
        tick();

        // Random legal traffic with occasional resets
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                reset_i = 0;
                dispatch(int'($urandom_range(0, 63)), 1, 1, 1);
                tick();
                reset_i = 1;
                continue;
            end
            for (int u = 0; u < 5; u++) begin
                if (q.size() > 0 && $urandom_range(0, 9) < 4)
                    finish(u, q[$urandom_range(0, q.size() - 1)].tag);
            end
            if (q.size() < 64 && $urandom_range(0, 9) < 6)
                dispatch((head + q.size()) % 64, 1'($urandom), int'($urandom_range(0, 31)), int'($urandom));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rob_commit_unit.md
# rob_commit_unit

Reorder buffer commit unit: the retire-side counterpart of the dispatch/rename stage. Dispatch writes one entry per cycle, indexed by the RRF tag that the rename allocator handed out. The five execution units mark entries finished. The block retires the oldest entry in program order and drives the completion interface back to rename: the ARF write-back/busy-clear and the RRF free count (`com_inst_num`).

## Interface
Parameters:
- `RRF_NUM`, 64, ROB/RRF entries; power of two.
- `RRF_SEL`, 6, log2(`RRF_NUM`).
- `REG_SEL`, 5, architectural register index width.
- `ADDR_LEN`, 32, PC width.

Ports. One clock; reset is synchronous and active-low.
- `clk_i`  in  1  clock; all state updates on rising edge.
- `reset_i`  in  1  synchronous, active-low reset.
- `dp_valid_i`  in  1  dispatch writes one entry this cycle.
- `dp_rrftag_i`  in  `RRF_SEL`  entry index (rename rrfptr/dst tag).
- `dp_dst_en_i`  in  1  instruction writes an architectural register.
- `dp_dstnum_i`  in  `REG_SEL`  architectural destination.
- `dp_pc_i`  in  `ADDR_LEN`  instruction PC.
- `fin_{alu1,alu2,ldst,mul,branch}_we_i`  in  1 each  unit finished an entry.
- `fin_{alu1,alu2,ldst,mul,branch}_tag_i`  in  `RRF_SEL` each  finished entry tag.
- `com_inst_num_o`  out  2  entries retired this cycle (0 or 1); frees RRF entries.
- `completed_we_o`  out  1  ARF write-back enable.
- `completed_dstnum_o`  out  `REG_SEL`  ARF destination.
- `completed_dst_rrftag_o`  out  `RRF_SEL`  tag being retired (ARF busy compare, RRF read).
- `commit_pc_o`  out  `ADDR_LEN`  PC of retiring entry.
- `rob_empty_o`  out  1  no valid entries.
- `proto_err_o`  out  1  sticky protocol error (see Configuration).

## Operation
- Per entry: `valid`, `finished`, `dst_en`, `dstnum`, `pc`. State: `comptr` (`RRF_SEL` bits, head), `count` (`RRF_SEL`+1 bits).
- Dispatch (`dp_valid_i`): the entry at `dp_rrftag_i` is set to valid=1 and finished=0, and dst_en, dstnum and pc are stored. Rename guarantees tags are allocated in order starting from `comptr`.
- Finish: for each asserted `fin_*_we_i`, the entry at `fin_*_tag_i` gets finished=1. Several units may finish different tags in the same cycle. Duplicate tags are harmless.
- Commit condition `cm = valid[comptr] & finished[comptr]`. When `cm` holds:
  - `com_inst_num_o`=1.
  - `completed_we_o`=`dst_en[comptr]`.
  - `completed_dstnum_o`, `completed_dst_rrftag_o`=`comptr` and `commit_pc_o` are driven from the head entry.
  - On the edge, the head entry becomes valid=0 and `comptr` advances by 1, wrapping `RRF_NUM`-1 to 0.
- When `cm` is 0, all commit outputs are 0. `completed_dst_rrftag_o`=`comptr` is still driven, but `completed_we_o`=0.
- `count` increments on dispatch and decrements on commit; it is unchanged when both happen. `rob_empty_o` = (`count`==0).
- Simultaneous events on the same entry:
  - Dispatch beats finish: the entry ends valid=1, finished=0.
  - Dispatch beats commit clear: the entry ends valid=1.
- Dispatch when `count`==`RRF_NUM` is illegal: the entry is overwritten and `count` saturates.

## Timing
- Commit outputs are combinational from registered state only; there are no input-to-output paths.
- Latency:
  - Dispatch at edge N, finish at edge N+1: commit outputs assert during cycle N+1→N+2 and the entry is freed at edge N+2.
  - Minimum dispatch-to-retire is 2 edges.
- Throughput: 1 retire per cycle. A run of k finished consecutive entries retires in k cycles.
- Reset (`reset_i`=0 at an edge), including mid-operation:
  - All valid and finished bits clear, `comptr`=0, `count`=0, `proto_err_o`=0.
  - Outputs read 0, except `rob_empty_o`=1.
  - Dispatch and finish inputs are ignored during reset cycles.
- Entry payload fields are not reset.

## Configuration
- `ROB_PROTOCOL_CHECK_EN` defined: `proto_err_o` sets (sticky until reset) on any of:
  - dispatch to an entry that is valid and not being committed that cycle;
  - finish to an invalid entry not dispatched that same cycle;
  - dispatch when `count`==`RRF_NUM`.
- `ROB_PROTOCOL_CHECK_EN` undefined: the check logic is absent and `proto_err_o` is tied 0.

## Test plan
- Reset, then idle → `rob_empty_o`=1, `com_inst_num_o`=0, `completed_we_o`=0, `proto_err_o`=0.
- Dispatch tag 0 (dst_en=1, dstnum=5, pc=0x100); finish tag 0 via alu1 next cycle → one cycle later: `com_inst_num_o`=1, `completed_we_o`=1, `completed_dstnum_o`=5, `completed_dst_rrftag_o`=0, `commit_pc_o`=0x100. The following cycle `rob_empty_o`=1.
- Dispatch tags 0,1,2; finish 2, then 1, then 0 (mul, branch, ldst) → no commit until tag 0 finishes, then retires 0,1,2 on three consecutive cycles in order.
- Dispatch tag 3 with dst_en=0 and finish it → `com_inst_num_o`=1, `completed_we_o`=0.
- Wrap: fill tags 62,63,0 (with `comptr` preset to 62 via prior traffic) and finish all → retire order 62,63,0; `comptr` wraps to 0 then 1.
- With `ROB_PROTOCOL_CHECK_EN`: finish tag 9 while tag 9 is invalid → `proto_err_o`=1 and it holds until reset. Assert reset mid-traffic → all state clears and the next dispatch to tag 0 retires normally.
